// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, resolves next-PC from D-stage redirects,
// reads instruction memory and counts fetches issued to D.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [2:0]  Move,
  input  logic [2:0]  Cmp,
  input  logic [31:0] D_PC,
  input  logic [31:0] EXT_Imm,
  input  logic [25:0] Instr_index,
  input  logic [31:0] CMP_RD1,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] F_Instr,
  output logic [31:0] F_PC,
  output logic [31:0] F_PC8,
  output logic [31:0] F_FetchCnt,
  output logic        F_Fault
);

  logic [31:0] pc;
  logic [31:0] fetch_cnt;
  logic [31:0] npc;
  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic        unused_cmp;

  // Cmp[2:1] are held for future blez/bgtz encodings
  assign unused_cmp = ^Cmp[2:1];

  assign seq_pc    = pc + 32'd4;
  assign br_target = D_PC + 32'd4 + EXT_Imm;

  always_comb begin
    npc = seq_pc;
    case (Move)
      3'd1:    npc = Cmp[0] ? br_target : seq_pc;
      3'd2:    npc = Cmp[0] ? seq_pc : br_target;
      3'd3:    npc = {D_PC[31:28], Instr_index, 2'b00};
      3'd4:    npc = CMP_RD1;
      default: npc = seq_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= PC_RESET;
      fetch_cnt <= 32'd0;
    end else if (!Stall) begin
      pc        <= npc;
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  assign F_Fault = (pc[1:0] != 2'b00) | (pc < IM_BASE) | (pc > IM_LIMIT);

  assign im_addr    = pc;
  assign F_PC       = pc;
  assign F_PC8      = pc + 32'd8;
  assign F_FetchCnt = fetch_cnt;
  assign F_Instr    = F_Fault ? 32'h0000_0000 : im_data;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: sequential fetch, branches,
// jumps, stall hold, fault detection and mid-run reset.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic [2:0]  Move;
  logic [2:0]  Cmp;
  logic [31:0] D_PC;
  logic [31:0] EXT_Imm;
  logic [25:0] Instr_index;
  logic [31:0] CMP_RD1;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic [31:0] F_Instr;
  logic [31:0] F_PC;
  logic [31:0] F_PC8;
  logic [31:0] F_FetchCnt;
  logic        F_Fault;

  int n_cmp;
  int n_err;

  fetch_stage dut (
    .clk(clk),
    .reset(reset),
    .Stall(Stall),
    .Move(Move),
    .Cmp(Cmp),
    .D_PC(D_PC),
    .EXT_Imm(EXT_Imm),
    .Instr_index(Instr_index),
    .CMP_RD1(CMP_RD1),
    .im_addr(im_addr),
    .im_data(im_data),
    .F_Instr(F_Instr),
    .F_PC(F_PC),
    .F_PC8(F_PC8),
    .F_FetchCnt(F_FetchCnt),
    .F_Fault(F_Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    Stall = 1'b0;
    Move = 3'd0;
    Cmp = 3'd0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (F_PC !== 32'h3000) begin
      n_err++;
      $display("FAIL reset_pc: got %h want %h", F_PC, 32'h3000);
    end
    n_cmp++;
    if (F_PC8 !== 32'h3008) begin
      n_err++;
      $display("FAIL reset_pc8: got %h want %h", F_PC8, 32'h3008);
    end
    n_cmp++;
    if (F_FetchCnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d want 0", F_FetchCnt);
    end
    n_cmp++;
    if (F_Fault !== 1'b0 || F_Instr !== 32'h2409_0001 || im_addr !== 32'h3000) begin
      n_err++;
      $display("FAIL reset_fetch: fault=%b instr=%h addr=%h want 0 24090001 3000",
               F_Fault, F_Instr, im_addr);
    end
  endtask

  task automatic test_seq();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h3004, 32'h3008, 32'h300C};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (F_PC !== exp_pc[i] || F_PC8 !== exp_pc[i] + 32'd8
          || F_FetchCnt !== 32'(i + 1)) begin
        n_err++;
        $display("FAIL seq_%0d: pc=%h pc8=%h cnt=%0d want %h %h %0d", i,
                 F_PC, F_PC8, F_FetchCnt, exp_pc[i], exp_pc[i] + 32'd8, i + 1);
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    step();
    step();
    D_PC = 32'h3004;
    EXT_Imm = 32'h10;
    Move = 3'd1;
    Cmp = 3'b001;
    step();
    n_cmp++;
    if (F_PC !== 32'h3018 || F_FetchCnt !== 32'd3) begin
      n_err++;
      $display("FAIL beq_taken: pc=%h cnt=%0d want 3018 3", F_PC, F_FetchCnt);
    end
    do_reset();
    step();
    step();
    Move = 3'd1;
    Cmp = 3'b000;
    step();
    n_cmp++;
    if (F_PC !== 32'h300C) begin
      n_err++;
      $display("FAIL beq_not_taken: pc=%h want 300c", F_PC);
    end
    D_PC = 32'h3008;
    EXT_Imm = 32'hFFFF_FFF8;
    Move = 3'd2;
    Cmp = 3'b110;
    step();
    n_cmp++;
    if (F_PC !== 32'h3004) begin
      n_err++;
      $display("FAIL bne_taken_back: pc=%h want 3004", F_PC);
    end
    Cmp = 3'b001;
    step();
    n_cmp++;
    if (F_PC !== 32'h3008) begin
      n_err++;
      $display("FAIL bne_not_taken: pc=%h want 3008", F_PC);
    end
    Move = 3'd0;
    Cmp = 3'd0;
  endtask

  task automatic test_jump();
    do_reset();
    D_PC = 32'h3010;
    Instr_index = 26'h0000C10;
    Move = 3'd3;
    step();
    n_cmp++;
    if (F_PC !== 32'h3040) begin
      n_err++;
      $display("FAIL jal: pc=%h want 3040", F_PC);
    end
    D_PC = 32'h9000_0000;
    Instr_index = 26'h0000C20;
    step();
    n_cmp++;
    if (F_PC !== 32'h9000_3080) begin
      n_err++;
      $display("FAIL j_region: pc=%h want 90003080", F_PC);
    end
    Move = 3'd4;
    CMP_RD1 = 32'h3100;
    step();
    n_cmp++;
    if (F_PC !== 32'h3100) begin
      n_err++;
      $display("FAIL jr: pc=%h want 3100", F_PC);
    end
    Move = 3'd5;
    step();
    n_cmp++;
    if (F_PC !== 32'h3104 || F_FetchCnt !== 32'd4) begin
      n_err++;
      $display("FAIL move5_seq: pc=%h cnt=%0d want 3104 4", F_PC, F_FetchCnt);
    end
    Move = 3'd0;
  endtask

  task automatic test_stall();
    do_reset();
    D_PC = 32'h3100;
    EXT_Imm = 32'h20;
    Move = 3'd1;
    Cmp = 3'b001;
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (F_PC !== 32'h3000 || F_FetchCnt !== 32'd0) begin
        n_err++;
        $display("FAIL stall_hold_%0d: pc=%h cnt=%0d want 3000 0", i,
                 F_PC, F_FetchCnt);
      end
    end
    Stall = 1'b0;
    step();
    n_cmp++;
    if (F_PC !== 32'h3124 || F_FetchCnt !== 32'd1) begin
      n_err++;
      $display("FAIL stall_release: pc=%h cnt=%0d want 3124 1", F_PC, F_FetchCnt);
    end
    Move = 3'd0;
    Cmp = 3'd0;
  endtask

  task automatic test_fault();
    do_reset();
    Move = 3'd4;
    CMP_RD1 = 32'h3002;
    step();
    n_cmp++;
    if (F_Fault !== 1'b1 || F_Instr !== 32'h0 || F_FetchCnt !== 32'd1) begin
      n_err++;
      $display("FAIL fault_misalign: fault=%b instr=%h cnt=%0d want 1 0 1",
               F_Fault, F_Instr, F_FetchCnt);
    end
    CMP_RD1 = 32'h7000;
    step();
    n_cmp++;
    if (F_Fault !== 1'b1 || F_Instr !== 32'h0) begin
      n_err++;
      $display("FAIL fault_above: fault=%b instr=%h want 1 0", F_Fault, F_Instr);
    end
    CMP_RD1 = 32'h6FFC;
    step();
    n_cmp++;
    if (F_Fault !== 1'b0 || F_Instr !== 32'h2409_0001 || F_PC8 !== 32'h7004) begin
      n_err++;
      $display("FAIL limit_ok: fault=%b instr=%h pc8=%h want 0 24090001 7004",
               F_Fault, F_Instr, F_PC8);
    end
    CMP_RD1 = 32'h2FFC;
    step();
    n_cmp++;
    if (F_Fault !== 1'b1) begin
      n_err++;
      $display("FAIL fault_below: fault=%b want 1", F_Fault);
    end
    CMP_RD1 = 32'hFFFF_FFFC;
    step();
    n_cmp++;
    if (F_Fault !== 1'b1 || F_PC8 !== 32'h4) begin
      n_err++;
      $display("FAIL pc8_wrap: fault=%b pc8=%h want 1 4", F_Fault, F_PC8);
    end
    Move = 3'd0;
    step();
    n_cmp++;
    if (F_PC !== 32'h0 || F_Fault !== 1'b1 || F_FetchCnt !== 32'd6) begin
      n_err++;
      $display("FAIL pc_wrap: pc=%h fault=%b cnt=%0d want 0 1 6",
               F_PC, F_Fault, F_FetchCnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step();
    step();
    reset = 1'b1;
    Stall = 1'b1;
    Move = 3'd3;
    D_PC = 32'h3010;
    Instr_index = 26'h0000C10;
    step();
    n_cmp++;
    if (F_PC !== 32'h3000 || F_FetchCnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid: pc=%h cnt=%0d want 3000 0", F_PC, F_FetchCnt);
    end
    reset = 1'b0;
    Stall = 1'b0;
    Move = 3'd0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    Stall = 1'b0;
    Move = 3'd0;
    Cmp = 3'd0;
    D_PC = 32'h0;
    EXT_Imm = 32'h0;
    Instr_index = 26'h0;
    CMP_RD1 = 32'h0;
    im_data = 32'h2409_0001;
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_stall();
    test_fault();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
F (fetch) stage of the 5-stage MIPS pipeline, directly upstream of the D stage. Owns the PC register and computes next-PC from redirect information resolved in D (branch compare result, jump index, jr register). Drives the instruction-memory read address and presents F_Instr/F_PC/F_PC8 to the D pipeline register. Honours the D-stage Stall and keeps a fetch counter for performance checks.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset.
IM_BASE, 32'h0000_3000, lowest legal fetch address.
IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
Stall  input  1  from D stage; 1 = hold PC and counter this cycle.
Move  input  3  redirect kind of the instruction in D: 0 seq, 1 beq, 2 bne, 3 j/jal, 4 jr, 5-7 treated as seq.
Cmp  input  3  D-stage compare result: [0] RD1==RD2, [1] RD1<RD2 signed, [2] RD1>RD2 signed.
D_PC  input  32  PC of the instruction in D.
EXT_Imm  input  32  branch offset, already sign-extended and shifted left by 2.
Instr_index  input  26  j/jal target field.
CMP_RD1  input  32  forwarded rs value (jr target).
im_addr  output  32  instruction-memory read address (= F_PC).
im_data  input  32  instruction-memory read data, combinational w.r.t. im_addr.
F_Instr  output  32  fetched instruction.
F_PC  output  32  current PC.
F_PC8  output  32  F_PC + 8 (link value).
F_FetchCnt  output  32  number of instructions issued to D since reset.
F_Fault  output  1  1 when F_PC is misaligned or outside [IM_BASE, IM_LIMIT].

Behaviour:
- Registers: PC (32), FetchCnt (32). Everything else combinational.
- Reset (sync, clk edge with reset=1): PC <= PC_RESET, FetchCnt <= 0. Reset wins over Stall and any redirect. After reset: F_PC=0x3000, F_PC8=0x3008, F_FetchCnt=0.
- im_addr = F_PC = PC; F_PC8 = PC + 8 (mod 2^32).
- F_Fault = (PC[1:0] != 0) | (PC < IM_BASE) | (PC > IM_LIMIT), unsigned compare.
- F_Instr = F_Fault ? 32'h0000_0000 (nop) : im_data.
- Next-PC (NPC), priority by Move:
  1 beq: Cmp[0] ? D_PC + 4 + EXT_Imm : PC + 4.
  2 bne: !Cmp[0] ? D_PC + 4 + EXT_Imm : PC + 4.
  3 j/jal: {D_PC[31:28], Instr_index, 2'b00}.
  4 jr: CMP_RD1 (no alignment fixup; a bad target shows as F_Fault next cycle).
  0,5,6,7: PC + 4.
  All adds wrap mod 2^32.
- Delay slot: the instruction in F while a branch/jump is in D is the delay slot; it is never squashed. NPC only redirects the fetch after it.
- Update rule each rising edge, reset=0:
  Stall=0: PC <= NPC; FetchCnt <= FetchCnt + 1 (wraps at 2^32).
  Stall=1: PC and FetchCnt hold. The redirect of a stalled branch in D is ignored that cycle and taken on the first cycle Stall=0, using the then-current Cmp/CMP_RD1 (forwarded values).
- Faulting fetch still advances PC as above, counts as a fetch, and passes nop to D.
- No combinational path from im_data to NPC; Stall→PC is register-enable only.
- Cmp[1], Cmp[2] unused by current Move encodings; reserved for blez/bgtz extensions.

Test Plan:
- Reset then 3 cycles Stall=0, Move=0 -> F_PC 0x3000, 0x3004, 0x3008, 0x300C; F_PC8 = F_PC+8; F_FetchCnt 0,1,2,3.
- D_PC=0x3004, Move=1, Cmp=3'b001, EXT_Imm=0x10 while F_PC=0x3008 -> next F_PC=0x3018; with Cmp=3'b000 -> 0x300C.
- Move=3, D_PC=0x3010, Instr_index=26'h0000C10 -> next F_PC=0x0000_3040; Move=4, CMP_RD1=0x3100 -> next F_PC=0x3100.
- Stall=1 for 2 cycles with Move=1, Cmp=3'b001 -> F_PC and F_FetchCnt constant; on Stall=0 PC jumps to D_PC+4+EXT_Imm, counter +1.
- Move=4, CMP_RD1=0x3002 -> F_Fault=1, F_Instr=0 despite im_data=0x2409_0001; CMP_RD1=0x7000 -> F_Fault=1; 0x6FFC -> F_Fault=0.
- Assert reset with Stall=1 and Move=3 mid-run -> next edge F_PC=0x3000, F_FetchCnt=0.
